// File: rtl/ga_issue_ctrl.sv
// GA issue/scoreboard controller: hazard-checks decoded GA instructions against
// a 32-entry write scoreboard, issues them to the GA execution unit over a
// req/ack handshake, tracks in-order completions and guards them with a watchdog.
package ibex_pkg;
  typedef enum logic [2:0] {
    GA_OP_NONE   = 3'd0,
    GA_OP_ALU    = 3'd1,
    GA_OP_MUL    = 3'd2,
    GA_OP_LDST   = 3'd3,
    GA_OP_STATUS = 3'd4
  } ga_op_sel_e;
endpackage

module ga_issue_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned Depth         = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       instr_valid_i,
  output logic       instr_ready_o,
  input  ga_op_sel_e op_sel_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       reg_we_i,
  input  logic [4:0] raddr_a_i,
  input  logic [4:0] raddr_b_i,
  input  logic [4:0] waddr_i,
  output logic       ex_req_o,
  input  logic       ex_ack_i,
  output ga_op_sel_e ex_op_o,
  output logic [2:0] ex_funct3_o,
  output logic [6:0] ex_funct7_o,
  output logic [4:0] ex_raddr_a_o,
  output logic [4:0] ex_raddr_b_o,
  output logic [4:0] ex_waddr_o,
  output logic       ex_we_o,
  input  logic       ex_done_i,
  output logic       busy_o,
  output logic       timeout_err_o,
  input  logic       err_clr_i
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned WdW  = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {RUN, FENCE, ERROR} state_e;

  typedef struct packed {
    logic [4:0] waddr;
    logic       we;
  } fifo_entry_t;

  state_e            state_q;
  logic [31:0]       sb_q, sb_d;
  fifo_entry_t       fifo_q [Depth];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   cnt_q, occ;
  logic [WdW-1:0]    wd_q;
  fifo_entry_t       head;
  logic              raw, waw, slot_ok, issue_free, fence_hit, accept;
  logic              push, pop, wd_hit;

  assign head       = fifo_q[rptr_q];
  assign raw        = sb_q[raddr_a_i] | sb_q[raddr_b_i];
  assign waw        = reg_we_i & sb_q[waddr_i];
  // The pending request counts as occupying a slot: it lands in the FIFO on ack.
  assign occ        = cnt_q + CntW'(ex_req_o);
  assign slot_ok    = occ < CntW'(Depth);
  assign issue_free = ~ex_req_o | ex_ack_i;
  assign busy_o     = ex_req_o | (cnt_q != '0);
  assign fence_hit  = instr_valid_i & (op_sel_i == GA_OP_STATUS) & busy_o;
  assign accept     = (state_q == RUN) & instr_valid_i & ~raw & ~waw & issue_free
                      & slot_ok & ~fence_hit;
  // Gate with reset so the stall signal drops immediately on an async reset.
  assign instr_ready_o = accept & rst_ni;

  assign push   = ex_req_o & ex_ack_i & (state_q != ERROR);
  assign pop    = ex_done_i & (cnt_q != '0) & (state_q != ERROR);
  // Oldest op has waited TimeoutCycles without completing.
  assign wd_hit = (cnt_q != '0) & ~pop & (wd_q == WdW'(TimeoutCycles - 1));

  // Scoreboard update: completion clears, a new issue sets; set is applied last.
  always_comb begin
    sb_d = sb_q;
    if (pop && head.we)       sb_d[head.waddr] = 1'b0;
    if (accept && reg_we_i)   sb_d[waddr_i]    = 1'b1;
  end

  // Control FSM with the sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RUN;
      timeout_err_o <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (wd_hit) begin
            state_q       <= ERROR;
            timeout_err_o <= 1'b1;
          end else if (fence_hit) begin
            state_q <= FENCE;
          end
        end
        FENCE: begin
          if (wd_hit) begin
            state_q       <= ERROR;
            timeout_err_o <= 1'b1;
          end else if (cnt_q == '0 && !ex_req_o) begin
            state_q <= RUN;
          end
        end
        ERROR: begin
          if (err_clr_i) begin
            state_q       <= RUN;
            timeout_err_o <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Issue register: captures an accepted instruction and holds it until ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_req_o     <= 1'b0;
      ex_op_o      <= GA_OP_NONE;
      ex_funct3_o  <= '0;
      ex_funct7_o  <= '0;
      ex_raddr_a_o <= '0;
      ex_raddr_b_o <= '0;
      ex_waddr_o   <= '0;
      ex_we_o      <= 1'b0;
    end else if (wd_hit) begin
      ex_req_o <= 1'b0;
    end else if (accept) begin
      ex_req_o     <= 1'b1;
      ex_op_o      <= op_sel_i;
      ex_funct3_o  <= funct3_i;
      ex_funct7_o  <= funct7_i;
      ex_raddr_a_o <= raddr_a_i;
      ex_raddr_b_o <= raddr_b_i;
      ex_waddr_o   <= waddr_i;
      ex_we_o      <= reg_we_i;
    end else if (ex_ack_i) begin
      ex_req_o <= 1'b0;
    end
  end

  // In-flight FIFO, scoreboard and watchdog; a timeout flushes all of them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) fifo_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      wd_q   <= '0;
      sb_q   <= '0;
    end else if (wd_hit) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      wd_q   <= '0;
      sb_q   <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= '{waddr: ex_waddr_o, we: ex_we_o};
        wptr_q         <= wptr_q + PtrW'(1);
      end
      if (pop) rptr_q <= rptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
      wd_q <= (cnt_q == '0 || pop) ? '0 : wd_q + WdW'(1);
      sb_q <= sb_d;
    end
  end

  // A completion with nothing in flight indicates an execution-unit protocol bug.
  done_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (ex_done_i && state_q != ERROR) |-> (cnt_q != '0));

endmodule

// File: tb/tb_ga_issue_ctrl.sv
// Directed bench for ga_issue_ctrl: a vector table for the steady-state cases
// plus hand sequences for the watchdog, ack hold-off and mid-operation reset.
module tb_ga_issue_ctrl;
  import ibex_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       instr_valid_i, instr_ready_o;
  ga_op_sel_e op_sel_i;
  logic [2:0] funct3_i;
  logic [6:0] funct7_i;
  logic       reg_we_i;
  logic [4:0] raddr_a_i, raddr_b_i, waddr_i;
  logic       ex_req_o, ex_ack_i;
  ga_op_sel_e ex_op_o;
  logic [2:0] ex_funct3_o;
  logic [6:0] ex_funct7_o;
  logic [4:0] ex_raddr_a_o, ex_raddr_b_o, ex_waddr_o;
  logic       ex_we_o, ex_done_i, busy_o, timeout_err_o, err_clr_i;

  int total  = 0;
  int passed = 0;

  always #5 clk_i = ~clk_i;

  ga_issue_ctrl #(.Depth(4), .TimeoutCycles(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .op_sel_i(op_sel_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .reg_we_i(reg_we_i), .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
    .waddr_i(waddr_i), .ex_req_o(ex_req_o), .ex_ack_i(ex_ack_i),
    .ex_op_o(ex_op_o), .ex_funct3_o(ex_funct3_o), .ex_funct7_o(ex_funct7_o),
    .ex_raddr_a_o(ex_raddr_a_o), .ex_raddr_b_o(ex_raddr_b_o),
    .ex_waddr_o(ex_waddr_o), .ex_we_o(ex_we_o), .ex_done_i(ex_done_i),
    .busy_o(busy_o), .timeout_err_o(timeout_err_o), .err_clr_i(err_clr_i)
  );

  typedef struct {
    logic       valid;
    ga_op_sel_e op;
    logic [4:0] ra, rb, wa;
    logic       we, ack, done, clr;
    logic       e_ready, e_req, e_busy, e_err;
  } vec_t;

  function automatic vec_t mk(input logic v, input ga_op_sel_e op,
                              input int ra, input int rb, input int wa,
                              input logic we, input logic ack, input logic done,
                              input logic clr, input logic er, input logic eq,
                              input logic eb, input logic ee);
    vec_t t;
    t.valid = v; t.op = op; t.ra = 5'(ra); t.rb = 5'(rb); t.wa = 5'(wa);
    t.we = we; t.ack = ack; t.done = done; t.clr = clr;
    t.e_ready = er; t.e_req = eq; t.e_busy = eb; t.e_err = ee;
    return t;
  endfunction

  // funct fields are derived from the destination so captured values are traceable
  function automatic logic [2:0] f3_of(input logic [4:0] wa);
    return wa[2:0] ^ 3'b101;
  endfunction
  function automatic logic [6:0] f7_of(input logic [4:0] wa);
    return {2'b01, wa};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input vec_t v);
    instr_valid_i = v.valid; op_sel_i = v.op;
    raddr_a_i = v.ra; raddr_b_i = v.rb; waddr_i = v.wa; reg_we_i = v.we;
    funct3_i = f3_of(v.wa); funct7_i = f7_of(v.wa);
    ex_ack_i = v.ack; ex_done_i = v.done; err_clr_i = v.clr;
  endtask

  // One cycle: drive just after the edge, sample on the falling edge.
  task automatic apply(input vec_t v, input string tag);
    @(posedge clk_i); #1;
    drive(v);
    @(negedge clk_i);
    chk({tag, ".ready"}, 32'(instr_ready_o), 32'(v.e_ready));
    chk({tag, ".req"},   32'(ex_req_o),      32'(v.e_req));
    chk({tag, ".busy"},  32'(busy_o),        32'(v.e_busy));
    chk({tag, ".err"},   32'(timeout_err_o), 32'(v.e_err));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ready"}, 32'(instr_ready_o), 0);
    chk({tag, ".req"},   32'(ex_req_o), 0);
    chk({tag, ".busy"},  32'(busy_o), 0);
    chk({tag, ".err"},   32'(timeout_err_o), 0);
    chk({tag, ".op"},    32'(ex_op_o), 32'(GA_OP_NONE));
    chk({tag, ".fields"}, 32'({ex_funct3_o, ex_funct7_o, ex_raddr_a_o,
                                ex_raddr_b_o, ex_waddr_o, ex_we_o}), 0);
  endtask

  localparam ga_op_sel_e ALU = GA_OP_ALU;
  localparam ga_op_sel_e ST  = GA_OP_STATUS;

  initial begin
    vec_t tbl[$];
    vec_t idle, held;

    idle = mk(0, ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // back-to-back independent ops, then drain while an op reading r3 waits
    tbl.push_back(mk(1, ALU, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, ALU, 0, 0, 2, 1, 1, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, ALU, 0, 0, 3, 1, 1, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, ALU, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, ALU, 3, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, ALU, 3, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, ALU, 3, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, ALU, 3, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, ALU, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, ALU, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(idle);
    // RAW on r5: B stalls until the cycle after done
    tbl.push_back(mk(1, ALU, 0, 0, 5, 1, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, ALU, 5, 0, 6, 1, 1, 0, 0, 0, 1, 1, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, ALU, 5, 0, 6, 1, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, ALU, 5, 0, 6, 1, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, ALU, 5, 0, 6, 1, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, ALU, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, ALU, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(idle);
    // fence: status op waits for two in-flight ops, plus one extra cycle in FENCE
    tbl.push_back(mk(1, ALU, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, ALU, 0, 0, 2, 1, 1, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, ST,  0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, ST,  0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, ST,  0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, ST,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, ST,  0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, ALU, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, ALU, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(idle);
    // depth limit: fifth op stalls until one completion
    tbl.push_back(mk(1, ALU, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, ALU, 0, 0, 2, 1, 1, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, ALU, 0, 0, 3, 1, 1, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, ALU, 0, 0, 4, 1, 1, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, ALU, 0, 0, 5, 1, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, ALU, 0, 0, 5, 1, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, ALU, 0, 0, 5, 1, 1, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, ALU, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, ALU, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(idle);

    // reset state
    rst_ni = 1'b0;
    drive(idle);
    #12;
    chk_all_zero("reset");
    rst_ni = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // watchdog: acked op never completes
    apply(mk(1, ALU, 0, 0, 7, 1, 1, 0, 0, 1, 0, 0, 0), "wd.issue");
    apply(mk(0, ALU, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0), "wd.ack");
    for (int i = 1; i <= 16; i++)
      apply(mk(0, ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), $sformatf("wd.wait%0d", i));
    apply(mk(1, ALU, 7, 0, 8, 1, 1, 0, 0, 0, 0, 0, 1), "wd.err");
    apply(mk(1, ALU, 7, 0, 8, 1, 1, 0, 1, 0, 0, 0, 1), "wd.clr");
    apply(mk(1, ALU, 7, 0, 8, 1, 1, 0, 0, 1, 0, 0, 0), "wd.reissue");
    apply(mk(0, ALU, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0), "wd.ack2");
    apply(mk(0, ALU, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0), "wd.done");
    apply(idle, "wd.idle");

    // ack held off: captured fields stay put, nothing pushed
    apply(mk(1, ALU, 3, 4, 9, 1, 0, 0, 0, 1, 0, 0, 0), "hold.issue");
    for (int i = 0; i < 3; i++) begin
      held = mk(1, GA_OP_MUL, 1, 2, 9, 1, 0, 0, 0, 0, 1, 1, 0);
      apply(held, $sformatf("hold%0d", i));
      chk($sformatf("hold%0d.op", i), 32'(ex_op_o), 32'(GA_OP_ALU));
      chk($sformatf("hold%0d.f", i), 32'({ex_funct3_o, ex_funct7_o}),
          32'({f3_of(5'd9), f7_of(5'd9)}));
      chk($sformatf("hold%0d.regs", i),
          32'({ex_raddr_a_o, ex_raddr_b_o, ex_waddr_o, ex_we_o}),
          32'({5'd3, 5'd4, 5'd9, 1'b1}));
    end
    apply(mk(0, ALU, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0), "hold.ack");
    apply(mk(1, ALU, 0, 0, 9, 1, 0, 1, 0, 0, 0, 1, 0), "hold.waw");
    apply(mk(1, ALU, 0, 0, 9, 1, 0, 0, 0, 1, 0, 0, 0), "hold.reissue");

    // reset while a request is pending and an instruction is presented
    @(posedge clk_i); #1;
    chk("rst.pre_req", 32'(ex_req_o), 1);
    rst_ni = 1'b0;
    #1;
    chk_all_zero("rst.mid");
    drive(idle);
    rst_ni = 1'b1;
    apply(idle, "rst.after");
    apply(mk(1, ALU, 9, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0), "rst.accept");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
